// File: rtl/adder_seq_pkg.sv
// Shared types and sizing for the adder operand sequencer.
package adder_seq_pkg;

  localparam int W_DEF             = 8;
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int CNT_W_DEF         = $clog2(SETTLE_CYCLES_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_B  = 2'd1,
    SETTLE = 2'd2,
    OUT    = 2'd3
  } seq_state_t;

  // Counter width able to hold the settle count itself.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adder_settle_timer.sv
// Down-counting settle timer: load with the settle count, done while the count reads 1.
module adder_settle_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          done
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done = en && (cnt_q == CW'(1));

endmodule

// File: rtl/adder_operand_sequencer.sv
// Stream front end for the W-bit ripple adder: takes A then B, waits SETTLE_CYCLES, presents the sum.
// Macro ADDSEQ_CARRY_CHAIN_EN feeds the previous pair's carry-out back as carry-in (LSB-first chains).
//
// state  | meaning
// IDLE   | waiting for operand A beat
// GET_B  | A held, waiting for operand B beat
// SETTLE | operands on the adder, ripple chain settling
// OUT    | sum captured and offered downstream
module adder_operand_sequencer
  import adder_seq_pkg::*;
#(
  parameter int W             = W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_first,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out,
  output logic         c_out,
  input  logic [W:0]   sum_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_sum,
  output logic         busy
);

  localparam int CW = cnt_width(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("adder_operand_sequencer: SETTLE_CYCLES must be >= 1");
  end

  seq_state_t   state_q, state_d;
  logic         a_take, b_take, capture, tmr_done;
  logic [W-1:0] a_q, b_q;
  logic [W:0]   sum_q;

  adder_settle_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (b_take),
    .load_val (CW'(SETTLE_CYCLES)),
    .en       (state_q == SETTLE),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    a_take   = 1'b0;
    b_take   = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_take  = 1'b1;
          state_d = GET_B;
        end
      end
      GET_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b_take  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_done) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      if (a_take)  a_q   <= in_data;
      if (b_take)  b_q   <= in_data;
      if (capture) sum_q <= sum_in;
    end
  end

`ifdef ADDSEQ_CARRY_CHAIN_EN
  logic first_q, carry_q, cin_q;

  // Carry-in is frozen at B accept so the later carry capture cannot disturb the settling adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q <= 1'b0;
      carry_q <= 1'b0;
      cin_q   <= 1'b0;
    end else begin
      if (a_take)  first_q <= in_first;
      if (b_take)  cin_q   <= first_q ? 1'b0 : carry_q;
      if (capture) carry_q <= sum_in[W];
    end
  end

  assign c_out = cin_q;
`else
  logic unused_first;
  assign unused_first = in_first;
  assign c_out        = 1'b0;
`endif

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign out_sum   = sum_q;
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Scoreboard bench for adder_operand_sequencer: directed cases plus randomized pairs vs an arithmetic model.
module tb_adder_operand_sequencer;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_first = 1'b0;
  logic [W-1:0] a_out, b_out;
  logic         c_out;
  logic [W:0]   sum_in;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W:0]   out_sum;
  logic         busy;

  adder_operand_sequencer #(.W(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .a_out(a_out), .b_out(b_out), .c_out(c_out), .sum_in(sum_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
  );

  // Ideal adder standing in for the parent's ripple adder.
  assign sum_in = {1'b0, a_out} + {1'b0, b_out} + {{W{1'b0}}, c_out};

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   sum;
    int           bacc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bp_force = 0;
  bit   rand_ready = 1'b0;
  bit   shown = 1'b0;
  bit   prev_carry = 1'b0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bp_force > 0) begin
      out_ready = 1'b0;
      bp_force  = bp_force - 1;
    end else if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
    else out_ready = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: new result -> latency/sum/operand checks; held result -> stability checks.
  always @(negedge clk) begin
    if (rst) shown = 1'b0;
    else if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
      else if (!shown) begin
        shown = 1'b1;
        chk("latency", 32'(cyc - exp_q[0].bacc), 32'(S));
        chk("out_sum", 32'(out_sum), 32'(exp_q[0].sum));
        chk("c_out", 32'(c_out), 32'(exp_q[0].cin));
        chk("a_out", 32'(a_out), 32'(exp_q[0].a));
        chk("b_out", 32'(b_out), 32'(exp_q[0].b));
      end else begin
        chk("hold_sum", 32'(out_sum), 32'(exp_q[0].sum));
        chk("hold_a", 32'(a_out), 32'(exp_q[0].a));
        chk("hold_b", 32'(b_out), 32'(exp_q[0].b));
      end
      chk("in_ready_in_out", 32'(in_ready), 32'd0);
      if (out_ready) begin
        shown = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  // Entered and left at a negedge; leaves in_valid low.
  task automatic send_beat(input logic [W-1:0] d, input logic f);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      $display("FAIL in_ready_timeout actual=0 required=1");
      errors++;
      checks++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "in_ready timeout");
    end
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic f, input int gap);
    exp_t e;
    send_beat(a, f);
    for (int i = 0; i < gap; i++) begin
      chk("gap_in_ready", 32'(in_ready), 32'd1);
      chk("gap_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    send_beat(b, ~f);
    e.a = a;
    e.b = b;
`ifdef ADDSEQ_CARRY_CHAIN_EN
    e.cin = f ? 1'b0 : prev_carry;
`else
    e.cin = 1'b0;
`endif
    e.sum      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, e.cin};
    prev_carry = e.sum[W];
    e.bacc     = last_acc;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_a_out", 32'(a_out), 32'd0);
    chk("rst_b_out", 32'(b_out), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);

    send_pair(8'h6A, 8'hBD, 1'b1, 0);
    drain();

    bp_force = 16;
    send_pair(8'h7F, 8'h80, 1'b1, 0);
    drain();

    send_pair(8'h01, 8'h01, 1'b1, 5);
    drain();

    send_pair(8'hFF, 8'h01, 1'b1, 0);
    send_pair(8'h00, 8'h00, 1'b0, 0);
    drain();

    // Asynchronous reset in the middle of SETTLE discards the pair.
    send_pair(8'h55, 8'h33, 1'b1, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_a_out", 32'(a_out), 32'd0);
    chk("midrst_b_out", 32'(b_out), 32'd0);
    chk("midrst_out_sum", 32'(out_sum), 32'd0);
    exp_q.delete();
    prev_carry = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_pair(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
